mux8_rr_sched: RTL and testbench

MUX8_RR_SCHED -- requirements
Module: mux8_rr_sched

---
 rtl/mux8_rr_sched.sv | 108 ++++++++++
 tb/tb_mux8_rr_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : mux8_rr_sched
// Description : Round-robin scheduler for an 8:1 data mux. It grants one
//               requesting channel at a time, limits each grant to MAX_HOLD
//               cycles and inserts a one-cycle gap between grants. All
//               outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mux8_rr_sched #(
  parameter int MAX_HOLD = 4  // max consecutive grant cycles, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] gnt,
  output logic       expired
);

  localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;    // first channel considered in the next arbitration
  logic [7:0] r_hold;   // cycles the current grant has been held

  logic [2:0] w_winner;
  logic [2:0] w_idx;
  logic       w_found;
  logic       w_any;
  logic       w_timeout;
  logic       w_exit;

  // Round-robin pick: first set request scanning upward from r_ptr, wrapping 7->0.
  always_comb begin
    w_winner = r_ptr;
    w_idx    = r_ptr;
    w_found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_idx = r_ptr + 3'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_any     = |req;
  assign w_timeout = (r_hold == c_MAX_HOLD);
  // A grant ends on acknowledge, on the grantee dropping its request, or on timeout.
  assign w_exit    = ack | ~req[sel] | w_timeout;

  // Scheduler state machine; every output is a flop updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd0;
      r_hold  <= 8'd0;
      sel     <= 3'd0;
      en      <= 1'b0;
      gnt     <= 8'h00;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (r_state)
        // IDLE and the one-cycle GAP behave alike: start a grant if anyone asks.
        // ack is ignored in both.
        S_IDLE, S_GAP: begin
          if (w_any) begin
            r_state <= S_GRANT;
            sel     <= w_winner;
            en      <= 1'b1;
            gnt     <= 8'b1 << w_winner;
            r_hold  <= 8'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (w_exit) begin
            r_state <= S_GAP;
            r_ptr   <= sel + 3'd1;   // wraps naturally modulo 8
            en      <= 1'b0;
            gnt     <= 8'h00;
            r_hold  <= 8'd0;
            // Only a pure timeout (still requesting, not acknowledging) is flagged.
            expired <= w_timeout & ~ack & req[sel];
          end else begin
            r_hold  <= r_hold + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux8_rr_sched
// Description : Self-checking bench for mux8_rr_sched. Expected output words
//               {en, sel, gnt, expired} are queued as stimulus is applied and
//               popped when the DUT has registered its response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_sched;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ack;

  logic [2:0] sel4, sel1;
  logic       en4, en1;
  logic [7:0] gnt4, gnt1;
  logic       exp4, exp1;

  logic [12:0] exp_q[$];
  int          n_total;
  int          n_bad;

  mux8_rr_sched #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .sel(sel4), .en(en4), .gnt(gnt4), .expired(exp4)
  );

  mux8_rr_sched #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .sel(sel1), .en(en1), .gnt(gnt1), .expired(exp1)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output words.
  function automatic logic [12:0] e_grant(input int ch);
    logic [7:0] oh;
    oh = 8'h01 << ch;
    return {1'b1, 3'(ch), oh, 1'b0};
  endfunction

  function automatic logic [12:0] e_off(input int ch, input logic xp);
    return {1'b0, 3'(ch), 8'h00, xp};
  endfunction

  task automatic apply_reset();
    rst = 1'b1; req = 8'h00; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got, want;
    rst = 1'b1; req = 8'hFF; ack = 1'b1;   // reset must win over requests
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin rst = 1'b0; req = 8'h00; end
      if (i >= 2) ack = i[0];                // ack in IDLE is ignored
      exp_q.push_back(e_off(0, 1'b0));
      @(posedge clk); #1;
      got = {en4, sel4, gnt4, exp4};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset[%0d] got=%04h want=%04h", i, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    logic [12:0] got, want;
    logic [12:0] ex [11];
    apply_reset();
    ex = '{e_grant(2), e_grant(2), e_grant(2), e_grant(2), e_off(2, 1'b1),
           e_grant(5), e_grant(5), e_grant(5), e_grant(5), e_off(5, 1'b1),
           e_grant(2)};
    for (int i = 0; i < 11; i++) begin
      req = 8'h24; ack = 1'b0;
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = {en4, sel4, gnt4, exp4};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL timeout[%0d] got=%04h want=%04h", i, got, want);
      end
    end
  endtask

  task automatic test_ack_wrap();
    logic [12:0] got, want;
    logic [7:0]  rq [9];
    logic        ak [9];
    logic [12:0] ex [9];
    apply_reset();
    rq = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h83, 8'h83, 8'h83, 8'h81, 8'h81};
    ak = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ex = '{e_grant(0), e_grant(0), e_off(0, 1'b0), e_grant(7), e_grant(7),
           e_grant(7), e_grant(7), e_off(7, 1'b1), e_grant(0)};
    for (int i = 0; i < 9; i++) begin
      req = rq[i]; ack = ak[i];
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = {en4, sel4, gnt4, exp4};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL ack_wrap[%0d] got=%04h want=%04h", i, got, want);
      end
    end
  endtask

  task automatic test_hold1();
    logic [12:0] got, want;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      req = 8'h08; ack = 1'b0;
      exp_q.push_back(i[0] ? e_off(3, 1'b1) : e_grant(3));
      @(posedge clk); #1;
      got = {en1, sel1, gnt1, exp1};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL hold1[%0d] got=%04h want=%04h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [12:0] got, want;
    logic        rs [6];
    logic [7:0]  rq [6];
    logic [12:0] ex [6];
    apply_reset();
    rs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rq = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    ex = '{e_grant(6), e_grant(6), e_grant(6), e_off(0, 1'b0),
           e_grant(0), e_grant(0)};
    for (int i = 0; i < 6; i++) begin
      rst = rs[i]; req = rq[i]; ack = 1'b0;
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = {en4, sel4, gnt4, exp4};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL rst_mid[%0d] got=%04h want=%04h", i, got, want);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_drop_req();
    logic [12:0] got, want;
    logic [7:0]  rq [5];
    logic [12:0] ex [5];
    apply_reset();
    rq = '{8'h24, 8'h24, 8'h20, 8'h24, 8'h24};
    ex = '{e_grant(2), e_grant(2), e_off(2, 1'b0), e_grant(5), e_grant(5)};
    for (int i = 0; i < 5; i++) begin
      req = rq[i]; ack = 1'b0;
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = {en4, sel4, gnt4, exp4};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL drop_req[%0d] got=%04h want=%04h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got, want;
    logic [12:0] ex [5];
    apply_reset();
    ex = '{e_grant(0), e_off(0, 1'b0), e_grant(1), e_off(1, 1'b0), e_grant(2)};
    for (int i = 0; i < 5; i++) begin
      req = 8'hFF; ack = i[0];
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = {en4, sel4, gnt4, exp4};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL back_to_back[%0d] got=%04h want=%04h", i, got, want);
      end
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; req = 8'h00; ack = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_timeout();
    test_ack_wrap();
    test_hold1();
    test_reset_mid_grant();
    test_drop_req();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
